// File: rtl/ddr3_cfg.sv
// DDR3 power-up sequencer and refresh scheduler driving the controller FSM config port.
// Define DDR3_CFG_FAST_INIT_EN to shorten the reset, CKE and ZQ waits for simulation.
module ddr3_cfg #(
  parameter int unsigned             DDR_FREQ_MHZ = 100,
  parameter int unsigned             DDR_ROW_BITS = 13,
  parameter logic [DDR_ROW_BITS-1:0] MR0_VAL      = DDR_ROW_BITS'('h0520),
  parameter logic [DDR_ROW_BITS-1:0] MR1_VAL      = DDR_ROW_BITS'('h0006),
  parameter logic [DDR_ROW_BITS-1:0] MR2_VAL      = DDR_ROW_BITS'('h0000),
  parameter logic [DDR_ROW_BITS-1:0] MR3_VAL      = DDR_ROW_BITS'('h0000)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  output logic                    ddr_rst_n_o,
  output logic                    ddr_cke_o,
  output logic                    cfg_req_o,
  input  logic                    cfg_rdy_i,
  output logic [2:0]              cfg_cmd_o,
  output logic [2:0]              cfg_ba_o,
  output logic [DDR_ROW_BITS-1:0] cfg_adr_o,
  output logic                    cfg_run_o,
  output logic                    cfg_ref_o
);

`ifdef DDR3_CFG_FAST_INIT_EN
  localparam int unsigned T_RST = 20;
  localparam int unsigned T_CKE = 50;
  localparam int unsigned T_ZQI = 32;
`else
  localparam int unsigned T_RST = DDR_FREQ_MHZ * 200;
  localparam int unsigned T_CKE = DDR_FREQ_MHZ * 500;
  localparam int unsigned T_ZQI = 512;
`endif
  localparam int unsigned T_XPR  = DDR_FREQ_MHZ * 170 / 1000 + 5;
  localparam int unsigned T_MRD  = 4;
  localparam int unsigned T_MOD  = 12;
  localparam int unsigned T_REFI = DDR_FREQ_MHZ * 78 / 10;

  // Shared counter must hold the longest load; fast init makes T_REFI the longest.
  localparam int unsigned MAX_A   = (T_CKE > T_RST) ? T_CKE : T_RST;
  localparam int unsigned MAX_B   = (T_REFI > T_ZQI) ? T_REFI : T_ZQI;
  localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [2:0] CMD_MRS  = 3'b000;
  localparam logic [2:0] CMD_ZQCL = 3'b110;
  localparam logic [2:0] CMD_NOP  = 3'b111;
  localparam logic [DDR_ROW_BITS-1:0] ZQ_ADR = DDR_ROW_BITS'('h0400);

  typedef enum logic [3:0] {
    ST_RST,
    ST_CKEW,
    ST_XPR,
    ST_MR2,
    ST_MR2_W,
    ST_MR3,
    ST_MR3_W,
    ST_MR1,
    ST_MR1_W,
    ST_MR0,
    ST_MR0_W,
    ST_ZQ,
    ST_ZQ_W,
    ST_RUN
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    rst_n_q, rst_n_d;
  logic                    cke_q, cke_d;
  logic                    req_q, req_d;
  logic [2:0]              cmd_q, cmd_d;
  logic [2:0]              ba_q, ba_d;
  logic [DDR_ROW_BITS-1:0] adr_q, adr_d;
  logic                    run_q, run_d;
  logic                    ref_q, ref_d;

  logic                    cnt_zero;
  logic [CNT_W-1:0]        cnt_dec;
  logic                    hs;

  assign cnt_zero = (cnt_q == '0);
  assign cnt_dec  = cnt_q - CNT_W'(1);
  assign hs       = req_q & cfg_rdy_i;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RST;
      cnt_q   <= CNT_W'(T_RST - 1);
      rst_n_q <= 1'b0;
      cke_q   <= 1'b0;
      req_q   <= 1'b0;
      cmd_q   <= CMD_NOP;
      ba_q    <= 3'b000;
      adr_q   <= '0;
      run_q   <= 1'b0;
      ref_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_n_q <= rst_n_d;
      cke_q   <= cke_d;
      req_q   <= req_d;
      cmd_q   <= cmd_d;
      ba_q    <= ba_d;
      adr_q   <= adr_d;
      run_q   <= run_d;
      ref_q   <= ref_d;
    end
  end

  // Next state plus registered outputs decoded from the state being entered.
  // Post-command waits load T-2 so the next command's handshake lands exactly T after this one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ref_d   = 1'b0;

    case (state_q)
      ST_RST: begin
        if (cnt_zero) begin
          state_d = ST_CKEW;
          cnt_d   = CNT_W'(T_CKE - 1);
        end else begin
          cnt_d = cnt_dec;
        end
      end
      ST_CKEW: begin
        if (cnt_zero) begin
          state_d = ST_XPR;
          cnt_d   = CNT_W'(T_XPR - 1);
        end else begin
          cnt_d = cnt_dec;
        end
      end
      ST_XPR: begin
        if (cnt_zero) state_d = ST_MR2;
        else          cnt_d   = cnt_dec;
      end
      ST_MR2: begin
        if (hs) begin
          state_d = ST_MR2_W;
          cnt_d   = CNT_W'(T_MRD - 2);
        end
      end
      ST_MR2_W: begin
        if (cnt_zero) state_d = ST_MR3;
        else          cnt_d   = cnt_dec;
      end
      ST_MR3: begin
        if (hs) begin
          state_d = ST_MR3_W;
          cnt_d   = CNT_W'(T_MRD - 2);
        end
      end
      ST_MR3_W: begin
        if (cnt_zero) state_d = ST_MR1;
        else          cnt_d   = cnt_dec;
      end
      ST_MR1: begin
        if (hs) begin
          state_d = ST_MR1_W;
          cnt_d   = CNT_W'(T_MRD - 2);
        end
      end
      ST_MR1_W: begin
        if (cnt_zero) state_d = ST_MR0;
        else          cnt_d   = cnt_dec;
      end
      ST_MR0: begin
        if (hs) begin
          state_d = ST_MR0_W;
          cnt_d   = CNT_W'(T_MOD - 2);
        end
      end
      ST_MR0_W: begin
        if (cnt_zero) state_d = ST_ZQ;
        else          cnt_d   = cnt_dec;
      end
      ST_ZQ: begin
        if (hs) begin
          state_d = ST_ZQ_W;
          cnt_d   = CNT_W'(T_ZQI - 1);
        end
      end
      ST_ZQ_W: begin
        if (cnt_zero) begin
          state_d = ST_RUN;
          cnt_d   = CNT_W'(T_REFI - 1);
        end else begin
          cnt_d = cnt_dec;
        end
      end
      ST_RUN: begin
        // Reload with T_REFI (not T_REFI-1) so the period includes the pulse cycle.
        if (cnt_zero) begin
          ref_d = 1'b1;
          cnt_d = CNT_W'(T_REFI);
        end else begin
          cnt_d = cnt_dec;
        end
      end
      default: begin
        state_d = ST_RST;
        cnt_d   = CNT_W'(T_RST - 1);
      end
    endcase

    rst_n_d = (state_d != ST_RST);
    cke_d   = !(state_d inside {ST_RST, ST_CKEW});
    run_d   = (state_d == ST_RUN);
    req_d   = 1'b0;
    cmd_d   = CMD_NOP;
    ba_d    = 3'b000;
    adr_d   = '0;

    case (state_d)
      ST_MR2: begin
        req_d = 1'b1;
        cmd_d = CMD_MRS;
        ba_d  = 3'd2;
        adr_d = MR2_VAL;
      end
      ST_MR3: begin
        req_d = 1'b1;
        cmd_d = CMD_MRS;
        ba_d  = 3'd3;
        adr_d = MR3_VAL;
      end
      ST_MR1: begin
        req_d = 1'b1;
        cmd_d = CMD_MRS;
        ba_d  = 3'd1;
        adr_d = MR1_VAL;
      end
      ST_MR0: begin
        req_d = 1'b1;
        cmd_d = CMD_MRS;
        ba_d  = 3'd0;
        adr_d = MR0_VAL;
      end
      ST_ZQ: begin
        req_d = 1'b1;
        cmd_d = CMD_ZQCL;
        ba_d  = 3'd0;
        adr_d = ZQ_ADR;
      end
      default: begin
      end
    endcase
  end

  assign ddr_rst_n_o = rst_n_q;
  assign ddr_cke_o   = cke_q;
  assign cfg_req_o   = req_q;
  assign cfg_cmd_o   = cmd_q;
  assign cfg_ba_o    = ba_q;
  assign cfg_adr_o   = adr_q;
  assign cfg_run_o   = run_q;
  assign cfg_ref_o   = ref_q;

endmodule

// File: tb/tb_ddr3_cfg.sv
// Self-checking bench for ddr3_cfg: power-up timing, command order, stall, refresh, mid-command reset.
module tb_ddr3_cfg;

`ifdef DDR3_CFG_FAST_INIT_EN
  localparam int unsigned FREQ  = 100;
  localparam int unsigned T_RST = 20;
  localparam int unsigned T_CKE = 50;
  localparam int unsigned T_ZQI = 32;
`else
  localparam int unsigned FREQ  = 10;
  localparam int unsigned T_RST = FREQ * 200;
  localparam int unsigned T_CKE = FREQ * 500;
  localparam int unsigned T_ZQI = 512;
`endif
  localparam int unsigned T_XPR  = FREQ * 170 / 1000 + 5;
  localparam int unsigned T_MRD  = 4;
  localparam int unsigned T_MOD  = 12;
  localparam int unsigned T_REFI = FREQ * 78 / 10;

  localparam logic [2:0]  MRS  = 3'b000;
  localparam logic [2:0]  ZQCL = 3'b110;
  localparam logic [23:0] RST_VEC = {5'b00000, 3'b111, 3'b000, 13'h0000};

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_rdy_i = 1'b0;
  logic        ddr_rst_n_o, ddr_cke_o, cfg_req_o, cfg_run_o, cfg_ref_o;
  logic [2:0]  cfg_cmd_o, cfg_ba_o;
  logic [12:0] cfg_adr_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_hs  = -1;

  typedef struct {
    logic [2:0]  cmd;
    logic [2:0]  ba;
    logic [12:0] adr;
    int          gap;
  } exp_t;
  exp_t exp_q[$];

  ddr3_cfg #(.DDR_FREQ_MHZ(FREQ), .DDR_ROW_BITS(13)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .ddr_rst_n_o(ddr_rst_n_o),
    .ddr_cke_o  (ddr_cke_o),
    .cfg_req_o  (cfg_req_o),
    .cfg_rdy_i  (cfg_rdy_i),
    .cfg_cmd_o  (cfg_cmd_o),
    .cfg_ba_o   (cfg_ba_o),
    .cfg_adr_o  (cfg_adr_o),
    .cfg_run_o  (cfg_run_o),
    .cfg_ref_o  (cfg_ref_o)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [23:0] out_vec();
    return {ddr_rst_n_o, ddr_cke_o, cfg_req_o, cfg_run_o, cfg_ref_o, cfg_cmd_o, cfg_ba_o, cfg_adr_o};
  endfunction

  function automatic logic pick(input int sel);
    case (sel)
      0:       return ddr_rst_n_o;
      1:       return ddr_cke_o;
      2:       return cfg_req_o;
      default: return cfg_run_o;
    endcase
  endfunction

  task automatic push_cmd(input logic [2:0] c, input logic [2:0] b, input logic [12:0] a, input int g);
    exp_t e;
    e.cmd = c; e.ba = b; e.adr = a; e.gap = g;
    exp_q.push_back(e);
  endtask

  // Returns the edge number of the first rise at or after the current sample point.
  task automatic wait_rise(input int sel, input int budget, output int edge_no, output bit ok);
    ok = 1'b0;
    edge_no = -1;
    for (int i = 0; i < budget; i++) begin
      if (pick(sel)) begin
        ok = 1'b1;
        edge_no = cyc;
        break;
      end
      @(negedge clock);
    end
  endtask

  // Returns the edge number on which the next not-yet-seen handshake takes place.
  task automatic wait_handshake(input int budget, output int edge_no, output bit ok);
    ok = 1'b0;
    edge_no = -1;
    for (int i = 0; i < budget; i++) begin
      if (cfg_req_o && cfg_rdy_i && (cyc + 1 != last_hs)) begin
        ok = 1'b1;
        edge_no = cyc + 1;
        last_hs = edge_no;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    cfg_rdy_i = 1'b1;
    repeat (3) @(negedge clock);
    n_checks++;
    if (out_vec() !== RST_VEC) begin
      n_fail++;
      $display("FAIL reset_values: got %h expected %h", out_vec(), RST_VEC);
    end
  endtask

  task automatic test_power_up(input int rel);
    int  e0, e1, e2;
    bit  ok;
    wait_rise(0, T_RST + 50, e0, ok);
    n_checks++;
    if (!ok || (e0 - rel) !== int'(T_RST)) begin
      n_fail++;
      $display("FAIL ddr_rst_n_rise: got %0d cycles expected %0d", e0 - rel, T_RST);
    end
    wait_rise(1, T_CKE + 50, e1, ok);
    n_checks++;
    if (!ok || (e1 - e0) !== int'(T_CKE)) begin
      n_fail++;
      $display("FAIL cke_rise: got %0d cycles expected %0d", e1 - e0, T_CKE);
    end
    wait_rise(2, T_XPR + 50, e2, ok);
    n_checks++;
    if (!ok || (e2 - e1) !== int'(T_XPR)) begin
      n_fail++;
      $display("FAIL first_req: got %0d cycles expected %0d", e2 - e1, T_XPR);
    end
  endtask

  // Pops n expectations and compares each against the command seen on its handshake.
  task automatic check_handshakes(input int n, output int hs_edge);
    int   prev = -1;
    int   e;
    bit   ok;
    exp_t x;
    hs_edge = -1;
    for (int k = 0; k < n; k++) begin
      wait_handshake(200, e, ok);
      n_checks++;
      if (!ok || exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL handshake_%0d: got none expected one (queue %0d)", k, exp_q.size());
        break;
      end
      x = exp_q.pop_front();
      if ({cfg_cmd_o, cfg_ba_o, cfg_adr_o} !== {x.cmd, x.ba, x.adr}) begin
        n_fail++;
        $display("FAIL cmd_%0d: got %b/%0d/%h expected %b/%0d/%h",
                 k, cfg_cmd_o, cfg_ba_o, cfg_adr_o, x.cmd, x.ba, x.adr);
      end
      if (x.gap > 0 && prev >= 0) begin
        n_checks++;
        if ((e - prev) !== x.gap) begin
          n_fail++;
          $display("FAIL gap_%0d: got %0d expected %0d", k, e - prev, x.gap);
        end
      end
      prev = e;
      hs_edge = e;
    end
  endtask

  task automatic test_cmd_sequence(output int zq_edge);
    exp_q.delete();
    push_cmd(MRS, 3'd2, 13'h0000, 0);
    push_cmd(MRS, 3'd3, 13'h0000, T_MRD);
    push_cmd(MRS, 3'd1, 13'h0006, T_MRD);
    push_cmd(MRS, 3'd0, 13'h0520, T_MRD);
    push_cmd(ZQCL, 3'd0, 13'h0400, T_MOD);
    check_handshakes(5, zq_edge);
  endtask

  task automatic test_run_refresh(input int zq_edge);
    int run_edge, prev, e, want;
    bit ok;
    wait_rise(3, T_ZQI + 50, run_edge, ok);
    n_checks++;
    if (!ok || (run_edge - zq_edge) !== int'(T_ZQI)) begin
      n_fail++;
      $display("FAIL run_rise: got %0d cycles expected %0d", run_edge - zq_edge, T_ZQI);
    end
    n_checks++;
    if ({cfg_ref_o, cfg_req_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL run_entry_quiet: got ref=%b req=%b expected 0 0", cfg_ref_o, cfg_req_o);
    end
    prev = run_edge;
    for (int p = 0; p < 4; p++) begin
      ok = 1'b0;
      for (int i = 0; i < int'(T_REFI) + 20; i++) begin
        @(negedge clock);
        if (cfg_ref_o) begin
          ok = 1'b1;
          break;
        end
      end
      e = cyc;
      want = (p == 0) ? int'(T_REFI) : int'(T_REFI) + 1;
      n_checks++;
      if (!ok || (e - prev) !== want) begin
        n_fail++;
        $display("FAIL refresh_%0d: got %0d cycles expected %0d", p, e - prev, want);
      end
      @(negedge clock);
      n_checks++;
      if ({cfg_ref_o, cfg_run_o} !== 2'b01) begin
        n_fail++;
        $display("FAIL refresh_width_%0d: got ref=%b run=%b expected 0 1", p, cfg_ref_o, cfg_run_o);
      end
      prev = e;
    end
  endtask

  task automatic test_stall_mr1(output int mr1_edge);
    int hs_edge, req_edge, e;
    bit ok;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n   = 1'b1;
    cfg_rdy_i = 1'b1;
    last_hs   = -1;
    test_power_up(cyc);
    exp_q.delete();
    push_cmd(MRS, 3'd2, 13'h0000, 0);
    push_cmd(MRS, 3'd3, 13'h0000, T_MRD);
    check_handshakes(2, hs_edge);
    @(posedge clock);
    #1 cfg_rdy_i = 1'b0;
    wait_rise(2, 50, req_edge, ok);
    n_checks++;
    if (!ok || (req_edge - hs_edge) !== int'(T_MRD) - 1) begin
      n_fail++;
      $display("FAIL mr1_req_rise: got %0d cycles expected %0d", req_edge - hs_edge, T_MRD - 1);
    end
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clock);
      n_checks++;
      if ({cfg_req_o, cfg_cmd_o, cfg_ba_o, cfg_adr_o} !== {1'b1, MRS, 3'd1, 13'h0006}) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: got %b/%b/%0d/%h expected 1/000/1/0006",
                 i, cfg_req_o, cfg_cmd_o, cfg_ba_o, cfg_adr_o);
      end
    end
    cfg_rdy_i = 1'b1;
    push_cmd(MRS, 3'd1, 13'h0006, 0);
    check_handshakes(1, e);
    n_checks++;
    if ((e - req_edge) !== 10) begin
      n_fail++;
      $display("FAIL stall_release: got %0d cycles expected 10", e - req_edge);
    end
    mr1_edge = e;
    @(posedge clock);
    #1 cfg_rdy_i = 1'b0;
  endtask

  task automatic test_reset_mid_cmd(input int mr1_edge);
    int req_edge, e;
    bit ok;
    wait_rise(2, 50, req_edge, ok);
    n_checks++;
    if (!ok || (req_edge - mr1_edge) !== int'(T_MRD) - 1 ||
        {cfg_cmd_o, cfg_ba_o, cfg_adr_o} !== {MRS, 3'd0, 13'h0520}) begin
      n_fail++;
      $display("FAIL mr0_pending: got %0d cycles %b/%0d/%h expected %0d 000/0/0520",
               req_edge - mr1_edge, cfg_cmd_o, cfg_ba_o, cfg_adr_o, T_MRD - 1);
    end
    repeat (3) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (out_vec() !== RST_VEC) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected %h", out_vec(), RST_VEC);
    end
    repeat (3) @(negedge clock);
    n_checks++;
    if (out_vec() !== RST_VEC) begin
      n_fail++;
      $display("FAIL reset_hold: got %h expected %h", out_vec(), RST_VEC);
    end
    reset_n   = 1'b1;
    cfg_rdy_i = 1'b1;
    last_hs   = -1;
    test_power_up(cyc);
    exp_q.delete();
    push_cmd(MRS, 3'd2, 13'h0000, 0);
    check_handshakes(1, e);
  endtask

  initial begin
    int zq_edge, mr1_edge;
    test_reset();
    reset_n = 1'b1;
    test_power_up(cyc);
    test_cmd_sequence(zq_edge);
    test_run_refresh(zq_edge);
    test_stall_mr1(mr1_edge);
    test_reset_mid_cmd(mr1_edge);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
